regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Imported by the interface, the top and the scoreboard.
package regfile_pkg;

   localparam int XLEN_D  = 32;
   localparam int NREGS_D = 32;
   localparam int NRD_D   = 2;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bundle of the register file.
// master drives requests, slave is the register file.
interface regfile_mp_if #(
   parameter int XLEN  = regfile_pkg::XLEN_D,
   parameter int NREGS = regfile_pkg::NREGS_D,
   parameter int NRD   = regfile_pkg::NRD_D
) ();

   localparam int AW = regfile_pkg::clog2(NREGS);

   logic                chip_en;
   logic                write_enable;
   logic [AW-1:0]       wr_port_add;
   logic [XLEN-1:0]     wr_port_data;
   logic [NRD*AW-1:0]   rd_address;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_pend;
   logic                pend_set;
   logic [AW-1:0]       pend_set_add;
   logic                init_busy;

   modport master (
      output chip_en, write_enable, wr_port_add,
      output wr_port_data, rd_address,
      output pend_set, pend_set_add,
      input  rd_data, rd_pend, init_busy
   );

   modport slave (
      input  chip_en, write_enable, wr_port_add,
      input  wr_port_data, rd_address,
      input  pend_set, pend_set_add,
      output rd_data, rd_pend, init_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for long-latency producers.
// Set beats clear on the same address; entry 0 can be hardwired idle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_D,
   parameter int AW       = clog2(NREGS),
   parameter bit ZERO_REG = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set_en,
   input  logic [AW-1:0]    i_set_add,
   input  logic             i_clr_en,
   input  logic [AW-1:0]    i_clr_add,
   output logic [NREGS-1:0] o_pend
);

   logic [NREGS-1:0] r_pend;
   logic             w_set;
   logic             w_clr;

   assign w_set = i_set_en &&
                  !(ZERO_REG && (i_set_add == '0));
   assign w_clr = i_clr_en &&
                  !(ZERO_REG && (i_clr_add == '0));

   // set is applied last so it wins on a shared address
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         if (w_clr) r_pend[i_clr_add] <= 1'b0;
         if (w_set) r_pend[i_set_add] <= 1'b1;
      end
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with bypass, scoreboard
// and a post-reset clear sweep that stalls the core.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_D,
   parameter int NREGS    = NREGS_D,
   parameter int NRD      = NRD_D,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic          clk,
   input logic          rst,
   regfile_mp_if.slave  bus
);

   localparam int AW = clog2(NREGS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_clr_ptr;
   logic [AW-1:0]    w_clr_ptr_nxt;
   logic             w_run;
   logic             w_wr_live;
   logic             w_wr_req;
   logic             w_set_req;
   logic             w_we;
   logic [AW-1:0]    w_wa;
   logic [XLEN-1:0]  w_wd;
   logic [XLEN-1:0]  w_mem [NREGS];
   logic [NREGS-1:0] w_pend;

   assign w_run     = (r_state == RUN);
   assign w_wr_live = w_run && bus.chip_en && bus.write_enable;
   assign w_wr_req  = w_wr_live &&
                      !(ZERO_REG && (bus.wr_port_add == '0));
   assign w_set_req = w_run && bus.chip_en && bus.pend_set;
   assign bus.init_busy = !w_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= INIT;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_we          = 1'b0;
      w_wa          = bus.wr_port_add;
      w_wd          = bus.wr_port_data;
      unique case (r_state)
         INIT: begin
            w_we          = !rst;
            w_wa          = r_clr_ptr;
            w_wd          = '0;
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            if (r_clr_ptr == AW'(NREGS - 1))
               w_state_nxt = RUN;
         end
         RUN: begin
            w_we = w_wr_req && !rst;
         end
         default: begin
            w_state_nxt = INIT;
         end
      endcase
   end

   // one register per entry, visible by name in waveforms
   for (genvar g = 0; g < NREGS; g++) begin : g_entry
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk) begin
         if (w_we && (w_wa == AW'(g))) r_q <= w_wd;
      end
      assign w_mem[g] = r_q;
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .i_set_en  (w_set_req),
      .i_set_add (bus.pend_set_add),
      .i_clr_en  (w_wr_req),
      .i_clr_add (bus.wr_port_add),
      .o_pend    (w_pend)
   );

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_zero;
      logic          w_fwd;
      logic          w_setk;
      assign w_ra   = bus.rd_address[p*AW +: AW];
      assign w_zero = ZERO_REG && (w_ra == '0);
      assign w_fwd  = BYPASS && w_wr_live &&
                      (bus.wr_port_add == w_ra);
      assign w_setk = bus.pend_set &&
                      (bus.pend_set_add == w_ra);
      assign bus.rd_data[p*XLEN +: XLEN] =
         (!w_run || w_zero) ? '0 :
         w_fwd ? bus.wr_port_data : w_mem[w_ra];
      assign bus.rd_pend[p] = w_run && w_pend[w_ra] &&
                              !(w_fwd && !w_setk);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing
// register file driven by the same stimulus.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        chip_en;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        ps;
   logic [4:0]  psa;
   logic [4:0]  ra0;
   logic [4:0]  ra1;

   int errors;
   int checks;
   int n;

   regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) b1 ();
   regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) b0 ();

   assign b1.chip_en      = chip_en;
   assign b1.write_enable = we;
   assign b1.wr_port_add  = wa;
   assign b1.wr_port_data = wd;
   assign b1.pend_set     = ps;
   assign b1.pend_set_add = psa;
   assign b1.rd_address   = {ra1, ra0};
   assign b0.chip_en      = chip_en;
   assign b0.write_enable = we;
   assign b0.wr_port_add  = wa;
   assign b0.wr_port_data = wd;
   assign b0.pend_set     = ps;
   assign b0.pend_set_add = psa;
   assign b0.rd_address   = {ra1, ra0};

   regfile_mp #(
      .XLEN(32), .NREGS(32), .NRD(2),
      .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   regfile_mp #(
      .XLEN(32), .NREGS(32), .NRD(2),
      .ZERO_REG(1'b1), .BYPASS(1'b0)
   ) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rst was just released after a posedge; count busy cycles
   task automatic sweep_count(output int cnt, input bit poke);
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!b1.init_busy) break;
         cnt++;
         if (poke) begin
            if (cnt == 4) begin
               chk("sweep_rd_data", b1.rd_data[31:0], 0);
               chk("sweep_rd_pend", b1.rd_pend, 0);
            end
            we  = (cnt >= 3 && cnt <= 5);
            ps  = (cnt >= 3 && cnt <= 5);
            wa  = 5'd1;
            psa = 5'd1;
            wd  = 32'hFFFF_FFFF;
            ra0 = 5'd1;
         end
      end
      we = 1'b0;
      ps = 1'b0;
   endtask

   initial begin
      clk = 0; rst = 1; chip_en = 0; we = 0;
      wa = 0; wd = 0; ps = 0; psa = 0;
      ra0 = 0; ra1 = 0;
      errors = 0; checks = 0;

      repeat (2) step();
      chk("rst_busy", b1.init_busy, 1);
      chk("rst_rd_data", b1.rd_data, 0);
      chk("rst_rd_pend", b1.rd_pend, 0);
      step();
      rst = 0;
      chip_en = 1;
      sweep_count(n, 1'b1);
      chk("sweep_len", n, 32);
      chk("busy_low", b1.init_busy, 0);

      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i);
         ra1 = 5'(31 - i);
         #1;
         chk($sformatf("clr_p0_x%0d", i), b1.rd_data[31:0], 0);
         chk($sformatf("clr_p1_x%0d", 31 - i),
             b1.rd_data[63:32], 0);
         chk($sformatf("clr_pend_x%0d", i), b1.rd_pend, 0);
      end

      step();
      we = 1; wa = 5; wd = 32'hDEAD_BEEF;
      ra0 = 5; ra1 = 5;
      #1;
      chk("byp_p0", b1.rd_data[31:0], 32'hDEAD_BEEF);
      chk("byp_p1", b1.rd_data[63:32], 32'hDEAD_BEEF);
      chk("nobyp_old", b0.rd_data[31:0], 0);
      step();
      we = 0;
      #1;
      chk("wr_b1", b1.rd_data, {2{32'hDEAD_BEEF}});
      chk("wr_b0", b0.rd_data, {2{32'hDEAD_BEEF}});

      step();
      we = 1; wa = 0; wd = 32'h1234_5678;
      ps = 1; psa = 0; ra0 = 0; ra1 = 0;
      #1;
      chk("x0_same_data", b1.rd_data, 0);
      chk("x0_same_pend", b1.rd_pend, 0);
      step();
      we = 0; ps = 0;
      #1;
      chk("x0_data", b1.rd_data, 0);
      chk("x0_pend", b1.rd_pend, 0);
      chk("x0_data_nb", b0.rd_data, 0);

      step();
      ps = 1; psa = 7; ra0 = 7; ra1 = 5;
      #1;
      chk("pend_k", b1.rd_pend, 2'b00);
      step();
      ps = 0;
      #1;
      chk("pend_k1", b1.rd_pend, 2'b01);
      chk("pend_k1_nb", b0.rd_pend, 2'b01);
      we = 1; wa = 7; wd = 32'h55;
      #1;
      chk("clr_byp_pend", b1.rd_pend, 2'b00);
      chk("clr_nobyp_pend", b0.rd_pend, 2'b01);
      chk("clr_nobyp_data", b0.rd_data[31:0], 0);
      step();
      we = 0;
      #1;
      chk("clr_pend", b1.rd_pend, 2'b00);
      chk("clr_pend_nb", b0.rd_pend, 2'b00);
      chk("x7_data", b0.rd_data[31:0], 32'h55);
      we = 1; wa = 7; wd = 32'h77;
      ps = 1; psa = 7;
      #1;
      chk("setclr_byp_data", b1.rd_data[31:0], 32'h77);
      chk("setclr_byp_pend", b1.rd_pend, 2'b00);
      step();
      we = 0; ps = 0;
      #1;
      chk("setclr_data", b1.rd_data[31:0], 32'h77);
      chk("setclr_pend", b1.rd_pend, 2'b01);
      chk("setclr_pend_nb", b0.rd_pend, 2'b01);

      chip_en = 0;
      we = 1; wa = 3; wd = 32'hAA;
      ps = 1; psa = 3; ra0 = 3; ra1 = 7;
      #1;
      chk("ce0_same", b1.rd_data[31:0], 0);
      chk("ce0_live", b1.rd_data[63:32], 32'h77);
      step();
      we = 0; ps = 0;
      #1;
      chk("ce0_data", b1.rd_data[31:0], 0);
      chk("ce0_pend", b1.rd_pend, 2'b10);
      chip_en = 1;

      we = 1; wa = 9; wd = 32'h99;
      step();
      we = 0;
      ra0 = 9;
      #1;
      chk("x9_data", b0.rd_data[31:0], 32'h99);

      rst = 1;
      step();
      rst = 0;
      repeat (10) @(negedge clk);
      chk("mid_busy", b1.init_busy, 1);
      step();
      rst = 1;
      step();
      step();
      chk("mid_rst_busy", b1.init_busy, 1);
      rst = 0;
      sweep_count(n, 1'b0);
      chk("mid_sweep_len", n, 32);
      ra0 = 9; ra1 = 7;
      #1;
      chk("mid_x9", b1.rd_data[31:0], 0);
      chk("mid_x7", b1.rd_data[63:32], 0);
      chk("mid_pend", b1.rd_pend, 2'b00);
      ra0 = 5;
      #1;
      chk("mid_x5_nb", b0.rd_data[31:0], 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
